// File: rtl/instr_rom_gen.sv
// instr_rom_gen: instruction memory that self-fills with pseudo-random RV32I words from an LFSR,
// then serves fetches and accepts test overrides through a write port.
module instr_rom_gen #(
    parameter int          DEPTH  = 1024,
    parameter int          ADDR_W = $clog2(DEPTH),
    parameter logic [31:0] SEED   = 32'hACE1_2025
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regen_i,
    input  logic [31:0]       seed_in_i,
    input  logic              haz_en_i,
    output logic              ready_o,
    input  logic              fetch_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [31:0]       instr_o,
    output logic              instr_valid_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_data_i
);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] SEED0 = (SEED == 32'h0) ? 32'h1 : SEED;

    typedef enum logic {FILL, READY} state_e;

    state_e            state_q;
    logic [31:0]       lfsr_q, lfsr_d, enc_d, instr_q, mem_wdata;
    logic [ADDR_W-1:0] idx_q, mem_waddr;
    logic [4:0]        prev_rd_q, prev_rd_d, rd, rs1, rs2;
    logic [2:0]        t, f3, bf3;
    logic [9:0]        im;
    logic [11:0]       imm_m;
    logic [12:1]       imm_b;
    logic [20:1]       imm_j;
    logic              f7s, alt, shift, filling, mem_we, valid_q;
    logic [31:0]       mem [DEPTH];

    assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
    assign t      = lfsr_d[2:0];
    assign rd     = lfsr_d[7:3];
    assign rs1    = haz_en_i ? prev_rd_q : lfsr_d[12:8];
    assign rs2    = lfsr_d[17:13];
    assign f3     = lfsr_d[20:18];
    assign f7s    = lfsr_d[21];
    assign im     = lfsr_d[31:22];
    assign imm_m  = {im, 2'b00};
    assign imm_b  = {im, 2'b00};
    assign imm_j  = {lfsr_d[31:14], 2'b00};
    assign alt    = f7s && (f3 == 3'd0 || f3 == 3'd5);
    assign shift  = (f3 == 3'd1 || f3 == 3'd5);
    assign bf3    = (f3 == 3'd2) ? 3'd4 : (f3 == 3'd3) ? 3'd5 : f3;

    always_comb begin
        case (t)
            3'd0:    enc_d = {alt ? 7'b0100000 : 7'b0, rs2, rs1, f3, rd, 7'b0110011};
            3'd1:    enc_d = {shift ? {f7s ? 7'b0100000 : 7'b0, rs2} : imm_m, rs1, f3, rd, 7'b0010011};
            3'd2:    enc_d = {imm_m, rs1, 3'b010, rd, 7'b0000011};
            3'd3:    enc_d = {imm_m[11:5], rs2, rs1, 3'b010, imm_m[4:0], 7'b0100011};
            3'd4:    enc_d = {imm_b[12], imm_b[10:5], rs2, rs1, bf3, imm_b[4:1], imm_b[11], 7'b1100011};
            3'd5:    enc_d = {imm_j[20], imm_j[10:1], imm_j[11], imm_j[19:12], rd, 7'b1101111};
            default: enc_d = NOP;
        endcase
    end

    // only rd-writing entries (R, I, LW, JAL) become the next hazard source
    assign prev_rd_d = (t <= 3'd2 || t == 3'd5) ? rd : prev_rd_q;

    assign filling   = (state_q == FILL);
    assign mem_we    = rst_n && (filling || (wr_en_i && !regen_i));
    assign mem_waddr = filling ? idx_q : wr_addr_i;
    assign mem_wdata = filling ? enc_d : wr_data_i;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            idx_q     <= '0;
            lfsr_q    <= SEED0;
            prev_rd_q <= '0;
            instr_q   <= NOP;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= fetch_en_i && !filling;
            if (fetch_en_i && !filling)
                instr_q <= mem[addr_i];
            if (filling) begin
                lfsr_q    <= lfsr_d;
                prev_rd_q <= prev_rd_d;
                idx_q     <= idx_q + 1'b1;
                if (idx_q == ADDR_W'(DEPTH - 1))
                    state_q <= READY;
            end else if (regen_i) begin
                lfsr_q    <= (seed_in_i == 32'h0) ? 32'h1 : seed_in_i;
                idx_q     <= '0;
                prev_rd_q <= '0;
                state_q   <= FILL;
            end
        end
    end

    assign ready_o       = (state_q == READY);
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
endmodule

// File: tb/tb_instr_rom_gen.sv
// tb_instr_rom_gen: randomized bench for instr_rom_gen comparing fills, fetches and writes
// against an instruction-level reference model.
module tb_instr_rom_gen;
    localparam int DEPTH = 16;
    localparam int AW = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0, rst_n = 1'b0, regen = 1'b0, haz_en = 1'b0, fetch_en = 1'b0, wr_en = 1'b0;
    logic [31:0] seed_in = '0, wr_data = '0, instr;
    logic [AW-1:0] addr = '0, wr_addr = '0;
    logic ready, instr_valid;
    int tests = 0, fails = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] golden [DEPTH];
    logic [31:0] obs [DEPTH];
    logic hz [DEPTH];

    always #5 clk = ~clk;

    instr_rom_gen #(.DEPTH(DEPTH), .SEED(32'h1)) dut (
        .clk(clk), .rst_n(rst_n), .regen_i(regen), .seed_in_i(seed_in), .haz_en_i(haz_en),
        .ready_o(ready), .fetch_en_i(fetch_en), .addr_i(addr), .instr_o(instr),
        .instr_valid_o(instr_valid), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
    );

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // one instruction from one LFSR state, assembled from offsets in standard RV32I formats
    function automatic logic [31:0] gen(input logic [31:0] r, input logic h, input logic [4:0] prd);
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [11:0] ii;
        logic [12:1] bo;
        logic [20:1] jo;
        rd = r[7:3];
        rs1 = h ? prd : r[12:8];
        rs2 = r[17:13];
        f3 = r[20:18];
        ii = 12'(r[31:22]) << 2;
        bo = 12'(r[31:22]) << 2;
        jo = 20'(r[31:14]) << 2;
        case (r[2:0])
            3'd0: return {(r[21] && (f3 == 3'd0 || f3 == 3'd5)) ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
            3'd1: return {(f3 == 3'd1 || f3 == 3'd5) ? ((r[21] ? 12'h400 : 12'h0) | 12'(rs2)) : ii, rs1, f3, rd, 7'h13};
            3'd2: return {ii, rs1, 3'd2, rd, 7'h03};
            3'd3: return {ii[11:5], rs2, rs1, 3'd2, ii[4:0], 7'h23};
            3'd4: return {bo[12], bo[10:5], rs2, rs1, f3 == 3'd2 ? 3'd4 : f3 == 3'd3 ? 3'd5 : f3, bo[4:1], bo[11], 7'h63};
            3'd5: return {jo[20], jo[10:1], jo[11], jo[19:12], rd, 7'h6F};
            default: return NOP;
        endcase
    endfunction

    task automatic build(input logic [31:0] seed);
        logic [31:0] s;
        logic [4:0] prd;
        s = (seed == 32'h0) ? 32'h1 : seed;
        prd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            s = step(s);
            model[i] = gen(s, hz[i], prd);
            if (s[2:0] <= 3'd2 || s[2:0] == 3'd5) prd = s[7:3];
        end
    endtask

    task automatic idle();
        regen = 0; haz_en = 0; fetch_en = 0; wr_en = 0;
    endtask

    // drives junk fetch/write/regen traffic (all of which must be ignored) while filling
    task automatic run_fill(input string name);
        int n = 0;
        while (!ready && n < 40) begin
            haz_en = hz[n % DEPTH];
            wr_en = 1'($urandom); wr_addr = AW'($urandom); wr_data = $urandom;
            fetch_en = 1'($urandom); addr = AW'($urandom);
            regen = 1'($urandom); seed_in = $urandom;
            @(posedge clk); #1;
            n++;
            tests++;
            if (instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL %s valid_during_fill cycle %0d: got %b want 0", name, n, instr_valid);
            end
        end
        idle();
        tests++;
        if (n !== DEPTH) begin
            fails++;
            $display("FAIL %s fill_length: got %0d cycles want %0d", name, n, DEPTH);
        end
    endtask

    task automatic read_all(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            fetch_en = 1; addr = AW'(i);
            @(posedge clk); #1;
            obs[i] = instr;
            tests++;
            if (instr_valid !== 1'b1 || instr !== model[i]) begin
                fails++;
                $display("FAIL %s word[%0d]: got valid=%b instr=%h want valid=1 instr=%h", name, i, instr_valid, instr, model[i]);
            end
            tests++;
            if (!(instr[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F})) begin
                fails++;
                $display("FAIL %s opcode[%0d]: got %h want RV32I subset opcode", name, i, instr[6:0]);
            end
        end
        fetch_en = 0;
    endtask

    task automatic check_hazard(input string name);
        logic [4:0] prd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (obs[i] !== NOP && obs[i][6:0] !== 7'h6F) begin
                tests++;
                if (obs[i][19:15] !== prd) begin
                    fails++;
                    $display("FAIL %s rs1[%0d]: got %0d want %0d", name, i, obs[i][19:15], prd);
                end
            end
            if (obs[i] !== NOP && obs[i][6:0] inside {7'h33, 7'h13, 7'h03, 7'h6F}) prd = obs[i][11:7];
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (ready !== 1'b0 || instr !== NOP || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got ready=%b instr=%h valid=%b want 0 %h 0", ready, instr, instr_valid, NOP);
        end
        for (int i = 0; i < DEPTH; i++) hz[i] = 0;
        rst_n = 1;
        run_fill("reset_fill");
        build(32'h1);
        golden = model;
    endtask

    task automatic test_first_fetch();
        fetch_en = 1; addr = '0;
        @(posedge clk); #1;
        fetch_en = 0;
        tests++;
        if (instr_valid !== 1'b1 || instr !== 32'h8000_2023) begin
            fails++;
            $display("FAIL first_fetch: got valid=%b instr=%h want 1 80002023", instr_valid, instr);
        end
        @(posedge clk); #1;
        tests++;
        if (instr_valid !== 1'b0 || instr !== 32'h8000_2023) begin
            fails++;
            $display("FAIL fetch_hold: got valid=%b instr=%h want 0 80002023", instr_valid, instr);
        end
    endtask

    task automatic test_fill_contents();
        read_all("seed1_contents");
    endtask

    task automatic test_write();
        wr_en = 1; wr_addr = 4'd5; wr_data = 32'hDEAD_BEEF; fetch_en = 1; addr = 4'd5;
        @(posedge clk); #1;
        wr_en = 0;
        tests++;
        if (instr_valid !== 1'b1 || instr !== model[5]) begin
            fails++;
            $display("FAIL write_read_first: got valid=%b instr=%h want 1 %h", instr_valid, instr, model[5]);
        end
        model[5] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        fetch_en = 0;
        tests++;
        if (instr_valid !== 1'b1 || instr !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL write_readback: got valid=%b instr=%h want 1 deadbeef", instr_valid, instr);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_i = instr;
        logic fe, we;
        logic [AW-1:0] ra, wa;
        logic [31:0] wd;
        for (int c = 0; c < 200; c++) begin
            fe = 1'($urandom); we = 1'($urandom); ra = AW'($urandom); wa = AW'($urandom); wd = $urandom;
            fetch_en = fe; addr = ra; wr_en = we; wr_addr = wa; wr_data = wd;
            @(posedge clk); #1;
            if (fe) exp_i = model[ra];
            if (we) model[wa] = wd;
            tests++;
            if (instr_valid !== fe || instr !== exp_i) begin
                fails++;
                $display("FAIL back_to_back cycle %0d: got valid=%b instr=%h want %b %h", c, instr_valid, instr, fe, exp_i);
            end
        end
        idle();
    endtask

    task automatic test_regen();
        regen = 1; seed_in = '0; fetch_en = 1; addr = 4'd3; wr_en = 1; wr_addr = 4'd3; wr_data = $urandom;
        @(posedge clk); #1;
        idle();
        tests++;
        if (ready !== 1'b0 || instr_valid !== 1'b1 || instr !== model[3]) begin
            fails++;
            $display("FAIL regen_cycle: got ready=%b valid=%b instr=%h want 0 1 %h", ready, instr_valid, instr, model[3]);
        end
        for (int i = 0; i < DEPTH; i++) hz[i] = 0;
        run_fill("regen_fill");
        model = golden;
        read_all("regen_contents");
    endtask

    task automatic test_hazard();
        logic [31:0] sd = $urandom;
        for (int i = 0; i < DEPTH; i++) hz[i] = 1;
        regen = 1; seed_in = sd;
        @(posedge clk); #1;
        idle();
        run_fill("haz_fill");
        build(sd);
        read_all("haz_contents");
        check_hazard("haz_rs1");
    endtask

    task automatic test_haz_mixed();
        logic [31:0] sd = $urandom;
        for (int i = 0; i < DEPTH; i++) hz[i] = 1'($urandom);
        regen = 1; seed_in = sd;
        @(posedge clk); #1;
        idle();
        run_fill("hazmix_fill");
        build(sd);
        read_all("hazmix_contents");
    endtask

    task automatic test_reset_midfill();
        regen = 1; seed_in = 32'h1234_5678;
        @(posedge clk); #1;
        idle();
        repeat (7) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        tests++;
        if (ready !== 1'b0 || instr !== NOP || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL midfill_reset: got ready=%b instr=%h valid=%b want 0 %h 0", ready, instr, instr_valid, NOP);
        end
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 0; i < DEPTH; i++) hz[i] = 0;
        run_fill("midfill_refill");
        model = golden;
        read_all("midfill_contents");
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_fill_contents();
        test_write();
        test_back_to_back();
        test_regen();
        test_hazard();
        test_haz_mixed();
        test_reset_midfill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/instr_rom_gen.md
Name: instr_rom_gen

Overview:
Parametrised successor to the team's random-instruction ROM. It is a synchronous instruction memory that self-fills with pseudo-random RV32I instructions (R, I, LW, SW, B, JAL, NOP) from a deterministic on-chip LFSR after reset or on request. Filling supports an optional RAW-hazard injection mode. It sits at the CPU fetch stage in CPU test builds and exposes a fetch handshake plus a test write port for overriding individual words.

Parameters:
DEPTH, 1024, number of 32-bit words (power of two, 4..4096)
ADDR_W, $clog2(DEPTH), word-address width
SEED, 32'hACE1_2025, LFSR reset seed; 0 is replaced by 32'h1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
regen  in  1  pulse: reseed from seed_in and refill
seed_in  in  32  seed used on regen; 0 is replaced by 32'h1
haz_en  in  1  sampled per fill cycle; enables hazard injection
ready  out  1  memory filled, accepting fetch and write
fetch_en  in  1  fetch request
addr  in  ADDR_W  word address (PC>>2)
instr  out  32  fetched instruction
instr_valid  out  1  instr is valid for the previous accepted fetch
wr_en  in  1  test write
wr_addr  in  ADDR_W  test write address
wr_data  in  32  test write data

Behaviour:
- Reset values: ready=0, instr=32'h00000013, instr_valid=0, state=FILL, idx=0, lfsr=SEED, prev_rd=0.
- LFSR: 32-bit right-shift Galois. next = (s>>1) ^ (s[0] ? 32'h80200003 : 0). Exactly one step per fill cycle; r = next state.
- Encoding from r:
  - Field extraction: t=r[2:0], rd=r[7:3], rs1=r[12:8], rs2=r[17:13], f3=r[20:18], f7s=r[21], im=r[31:22].
  - t=0, R-type (0110011): funct7 = 7'b0100000 if f7s and f3∈{0,5}, else 0.
  - t=1, I-type (0010011): imm = {im,2'b00}. If f3∈{1,5}, imm = {f7s?7'b0100000:7'b0, rs2}.
  - t=2, LW (0000011): f3 forced to 010, imm = {im,2'b00}.
  - t=3, SW (0100011): f3=010, imm = {im,2'b00} split as imm[11:5], imm[4:0].
  - t=4, Branch (1100011): imm[12:1] = {im,2'b00}. f3 2→4, 3→5, others unchanged.
  - t=5, JAL (1101111): imm[20:1] = {r[31:14],2'b00}, standard bit scramble.
  - t=6/7: NOP 32'h00000013.
- Hazard mode: if haz_en is high during a fill cycle, rs1 is replaced by prev_rd. prev_rd updates to rd after each R/I/LW/JAL entry only.
- FSM FILL:
  - Each cycle: mem[idx] <= enc(r), lfsr <= r, idx++.
  - After writing idx=DEPTH-1, go to READY with ready=1 on the next cycle. Fill takes exactly DEPTH cycles.
- FSM READY:
  - regen=1 → lfsr <= seed_in (0→1), idx=0, prev_rd=0, ready=0, go to FILL.
  - regen during FILL is ignored.
- Fetch:
  - fetch_en && ready → next cycle instr = mem[addr], instr_valid=1.
  - Otherwise instr_valid=0 and instr holds its value.
  - fetch_en while !ready is dropped.
- Test write:
  - wr_en && ready → mem[wr_addr] <= wr_data.
  - Ignored during FILL.
  - Same-cycle fetch of the same address returns old data (read-first).
- regen coincident with fetch or write in READY: the fetch completes normally; the write is discarded.
- rst_n low mid-fill: fill aborts immediately; it restarts from SEED after release.
- Address width is exact; no wrap logic is needed.

Test Plan:
- DEPTH=16, SEED=1, release reset → ready rises on the 16th clk edge after release; fetch addr 0 → instr=32'h80002023, instr_valid=1 one cycle later.
- READY, fetch_en=1 for addr 0..15 consecutively → instr_valid high on each following cycle. Every word has opcode in {33,13,03,23,63,6F} or equals 32'h00000013, matching a bench LFSR reference model bit-exactly.
- haz_en=1 during fill → for every entry after the first R/I/LW/JAL entry, rs1 (bits 19:15) equals the rd of the most recent R/I/LW/JAL entry.
- wr_en addr 5 data 32'hDEADBEEF with same-cycle fetch addr 5 → old word returned. Next fetch of addr 5 → 32'hDEADBEEF. wr_en during FILL → no effect.
- regen with seed_in=0 in READY → ready=0 next cycle, refill lasts 16 cycles, contents identical to the SEED=1 run; regen pulses during the refill are ignored.
- rst_n asserted at fill cycle 7 → ready=0 and instr=32'h00000013 immediately; after release, full 16-cycle fill and contents equal the first run.
